// File: rtl/if_id_stage.sv
// Elastic IF/ID pipeline stage: main + skid register pair with valid/ready handshake,
// synchronous flush that inserts NOPs, and saturating stall/flush event counters.
module if_id_stage #(
    parameter int                  PC_W      = 32,
    parameter int                  INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0000,
    parameter int                  CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [PC_W-1:0]    main_pc_r;
    logic [INSTR_W-1:0] main_instr_r;
    logic [PC_W-1:0]    skid_pc_r;
    logic [INSTR_W-1:0] skid_instr_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               accept_s;
    logic               pop_s;
    logic               load_main_in_s;
    logic               load_main_skid_s;
    logic               load_skid_s;

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = TWO;
                        load_skid_s = 1'b1;
                    end else if (pop_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State register; ready/valid are registered from the next state so they depend on state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Main and skid data registers; flush wipes both to the NOP bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_pc_r    <= {PC_W{1'b0}};
            main_instr_r <= NOP_INSTR;
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= NOP_INSTR;
        end else if (flush) begin
            main_pc_r    <= {PC_W{1'b0}};
            main_instr_r <= NOP_INSTR;
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= NOP_INSTR;
        end else begin
            if (load_main_in_s) begin
                main_pc_r    <= in_pc;
                main_instr_r <= in_instr;
            end else if (load_main_skid_s) begin
                main_pc_r    <= skid_pc_r;
                main_instr_r <= skid_instr_r;
            end else begin
                main_pc_r    <= main_pc_r;
                main_instr_r <= main_instr_r;
            end
            if (load_skid_s) begin
                skid_pc_r    <= in_pc;
                skid_instr_r <= in_instr;
            end else begin
                skid_pc_r    <= skid_pc_r;
                skid_instr_r <= skid_instr_r;
            end
        end
    end

    // Saturating stall and flush counters; a stall during a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush && (state_r != EMPTY) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pc    = main_pc_r;
    assign out_instr = out_valid_r ? main_instr_r : NOP_INSTR;
    assign occupancy = state_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, hand sequences for
// flush/reset/saturation, and random traffic checked against a queue-based model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_instr;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } bnd_t;

    bnd_t        q[$];
    int          stall_m;
    int          flush_m;
    logic [31:0] last_pc_m;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_occ;
        int          e_stall;
    } vec_t;

    vec_t tbl[10];

    if_id_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_instr(s_out_instr), .occupancy(s_occupancy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
    endtask

    task automatic model_reset();
        q.delete();
        stall_m   = 0;
        flush_m   = 0;
        last_pc_m = 32'h0;
    endtask

    task automatic compare_model();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_pc", out_pc, (q.size() > 0) ? q[0].pc : last_pc_m);
        chk("out_instr", out_instr, (q.size() > 0) ? q[0].instr : 32'h0);
        chk("occupancy", occupancy, q.size());
        chk("stall_cnt", stall_cnt, sat(stall_m, 65535));
        chk("flush_cnt", flush_cnt, sat(flush_m, 65535));
        chk("sat_stall_cnt", s_stall_cnt, sat(stall_m, 7));
        chk("sat_flush_cnt", s_flush_cnt, sat(flush_m, 7));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit   rdy;
        bit   vld;
        bnd_t b;
        rdy = (q.size() < 2);
        vld = (q.size() > 0);
        if (vld && !out_ready) stall_m++;
        if (flush) begin
            if (q.size() != 0) flush_m++;
            q.delete();
            last_pc_m = 32'h0;
        end else begin
            if (vld && out_ready) q.delete(0);
            if (in_valid && rdy) begin
                b.pc    = in_pc;
                b.instr = in_instr;
                q.push_back(b);
            end
            if (q.size() > 0) last_pc_m = q[0].pc;
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'd4,     32'h11, 1'b1, 1'b1, 1'b1, 32'd4,     32'h11, 2'd1, 0};
        tbl[1] = '{1'b0, 1'b1, 32'd8,     32'h22, 1'b1, 1'b1, 1'b1, 32'd8,     32'h22, 2'd1, 0};
        tbl[2] = '{1'b0, 1'b1, 32'd12,    32'h33, 1'b1, 1'b1, 1'b1, 32'd12,    32'h33, 2'd1, 0};
        tbl[3] = '{1'b0, 1'b0, 32'd0,     32'h00, 1'b1, 1'b0, 1'b1, 32'd12,    32'h00, 2'd0, 0};
        tbl[4] = '{1'b0, 1'b1, 32'h100,   32'hA1, 1'b0, 1'b1, 1'b1, 32'h100,   32'hA1, 2'd1, 0};
        tbl[5] = '{1'b0, 1'b1, 32'h104,   32'hA2, 1'b0, 1'b1, 1'b0, 32'h100,   32'hA1, 2'd2, 1};
        tbl[6] = '{1'b0, 1'b1, 32'h108,   32'hA3, 1'b0, 1'b1, 1'b0, 32'h100,   32'hA1, 2'd2, 2};
        tbl[7] = '{1'b0, 1'b1, 32'h108,   32'hA3, 1'b1, 1'b1, 1'b1, 32'h104,   32'hA2, 2'd1, 2};
        tbl[8] = '{1'b0, 1'b1, 32'h108,   32'hA3, 1'b1, 1'b1, 1'b1, 32'h108,   32'hA3, 2'd1, 2};
        tbl[9] = '{1'b0, 1'b0, 32'd0,     32'h00, 1'b1, 1'b0, 1'b1, 32'h108,   32'h00, 2'd0, 2};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        rst = 1'b0;

        // Streaming and back-pressure vectors
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
            step();
            chk("tbl_valid", out_valid, tbl[i].e_valid);
            chk("tbl_ready", in_ready, tbl[i].e_ready);
            chk("tbl_pc", out_pc, tbl[i].e_pc);
            chk("tbl_instr", out_instr, tbl[i].e_instr);
            chk("tbl_occ", occupancy, tbl[i].e_occ);
            chk("tbl_stall", stall_cnt, tbl[i].e_stall);
        end

        // Flush with two entries held and a bundle offered in the same cycle
        drive(1'b0, 1'b1, 32'h200, 32'hC1, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h204, 32'hC2, 1'b0);
        step();
        chk("pre_flush_occ", occupancy, 2'd2);
        drive(1'b1, 1'b1, 32'h208, 32'hBB, 1'b0);
        step();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_instr", out_instr, 32'h0);
        chk("flush_pc", out_pc, 32'h0);
        chk("flush_cnt_1", flush_cnt, 16'd1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("flush_empty_cnt", flush_cnt, 16'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("bb_dropped_occ", occupancy, 2'd0);

        // Flush coinciding with a pop from ONE
        drive(1'b0, 1'b1, 32'h300, 32'hD1, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("flush_pop_valid", out_valid, 1'b0);
        chk("flush_pop_occ", occupancy, 2'd0);
        chk("flush_pop_cnt", flush_cnt, 16'd2);

        // Long stall saturates the narrow counter
        drive(1'b0, 1'b1, 32'h400, 32'hE1, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("sat_stall_7", s_stall_cnt, 3'd7);

        // Asynchronous reset with two entries held
        drive(1'b0, 1'b1, 32'h404, 32'hE2, 1'b0);
        step();
        chk("pre_rst_occ", occupancy, 2'd2);
        rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_occ", occupancy, 2'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_flush", flush_cnt, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(15) == 0), $urandom_range(1), $urandom, $urandom,
                  ($urandom_range(2) != 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
